// File: rtl/bp_me_dma_mem_responder.sv
// bp_me_dma_mem_responder: block-memory stand-in for DRAM behind one bsg_cache DMA port
// Ports:
//   clk_i, reset_n_i                  clock, asynchronous active-low reset
//   dma_pkt_i / _v_i / _ready_and_o   packet {write_not_read, mask, addr}, addr at the LSBs
//   dma_data_o / _v_o / _ready_and_i  read fill beats returned to the cache
//   dma_data_i / _v_i / _ready_and_o  write fill beats absorbed from the cache
module bp_me_dma_mem_responder #(
  parameter int daddr_width_p = 28,
  parameter int word_width_p = 64,
  parameter int block_size_in_words_p = 8,
  parameter int fill_width_p = 64,
  parameter int mem_els_p = 1024
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic [block_size_in_words_p+daddr_width_p:0] dma_pkt_i,
  input  logic dma_pkt_v_i,
  output logic dma_pkt_ready_and_o,
  output logic [fill_width_p-1:0] dma_data_o,
  output logic dma_data_v_o,
  input  logic dma_data_ready_and_i,
  input  logic [fill_width_p-1:0] dma_data_i,
  input  logic dma_data_v_i,
  output logic dma_data_ready_and_o
);
  localparam int beats = block_size_in_words_p*word_width_p/fill_width_p;
  localparam int wpb = fill_width_p/word_width_p;
  localparam int block_bytes = block_size_in_words_p*word_width_p/8;
  localparam int blocks = mem_els_p/beats;
  localparam int lg_beats = beats > 1 ? $clog2(beats) : 1;
  localparam int lg_blocks = blocks > 1 ? $clog2(blocks) : 1;
  localparam int lg_els = mem_els_p > 1 ? $clog2(mem_els_p) : 1;
  typedef enum logic [1:0] {e_idle, e_read, e_write} state_e;
  logic [fill_width_p-1:0] mem [mem_els_p];
  state_e state_r, state_n;
  logic [lg_beats-1:0] cnt_r, cnt_n;
  logic [block_size_in_words_p-1:0] mask_r, mask_n;
  logic [lg_blocks-1:0] blk_r, blk_n;
  logic [daddr_width_p-1:0] addr;
  logic [lg_els-1:0] entry;
  logic [wpb-1:0] mslice;
  logic wnr, pkt_hs, rd_hs, wr_hs, last;
  assign addr = dma_pkt_i[daddr_width_p-1:0];
  assign wnr = dma_pkt_i[daddr_width_p+block_size_in_words_p];
  assign entry = lg_els'(blk_r) * lg_els'(beats) + lg_els'(cnt_r);
  assign mslice = wpb'(mask_r >> (int'(cnt_r) * wpb));
  assign last = cnt_r == lg_beats'(beats-1);
  // reset_n_i gates ready so the packet port reads busy while reset is held
  assign dma_pkt_ready_and_o = reset_n_i & (state_r == e_idle);
  assign dma_data_v_o = state_r == e_read;
  assign dma_data_ready_and_o = state_r == e_write;
  assign dma_data_o = dma_data_v_o ? mem[entry] : '0;
  assign pkt_hs = dma_pkt_v_i & dma_pkt_ready_and_o;
  assign rd_hs = dma_data_v_o & dma_data_ready_and_i;
  assign wr_hs = dma_data_v_i & dma_data_ready_and_o;
  always_comb begin
    state_n = state_r;
    cnt_n = cnt_r;
    mask_n = mask_r;
    blk_n = blk_r;
    if (pkt_hs) begin
      state_n = wnr ? e_write : e_read;
      cnt_n = '0;
      mask_n = dma_pkt_i[daddr_width_p+:block_size_in_words_p];
      // offset bits are dropped and out-of-range blocks wrap onto the store
      blk_n = lg_blocks'((addr / daddr_width_p'(block_bytes)) % daddr_width_p'(blocks));
    end else if (rd_hs | wr_hs) begin
      cnt_n = last ? '0 : cnt_r + 1'b1;
      state_n = last ? e_idle : state_r;
    end
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_r <= e_idle;
      cnt_r <= '0;
      mask_r <= '0;
      blk_r <= '0;
    end else begin
      state_r <= state_n;
      cnt_r <= cnt_n;
      mask_r <= mask_n;
      blk_r <= blk_n;
    end
  always_ff @(posedge clk_i)
    if (wr_hs)
      for (int k = 0; k < wpb; k++)
        if (mslice[k]) mem[entry][k*word_width_p+:word_width_p] <= dma_data_i[k*word_width_p+:word_width_p];
endmodule

// File: tb/tb_bp_me_dma_mem_responder.sv
// tb_bp_me_dma_mem_responder: randomized bench against a word-level model of the DMA responder
module tb_bp_me_dma_mem_responder;
  localparam int aw = 28;
  localparam int mw = 8;
  logic clk = 0;
  logic reset_n = 1;
  logic [mw+aw:0] pkt = '0;
  logic pkt_v = 0;
  logic pkt_ready;
  logic [63:0] d_o;
  logic d_v_o;
  logic d_rdy_i = 0;
  logic [63:0] d_i = '0;
  logic d_v_i = 0;
  logic d_rdy_o;
  int checks = 0;
  int failures = 0;
  logic [63:0] mdl [1024];
  logic [63:0] wbuf [8];
  always #5 clk = ~clk;
  bp_me_dma_mem_responder dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .dma_pkt_i(pkt), .dma_pkt_v_i(pkt_v), .dma_pkt_ready_and_o(pkt_ready),
    .dma_data_o(d_o), .dma_data_v_o(d_v_o), .dma_data_ready_and_i(d_rdy_i),
    .dma_data_i(d_i), .dma_data_v_i(d_v_i), .dma_data_ready_and_o(d_rdy_o)
  );
  function automatic int blk_of(logic [aw-1:0] a);
    return int'((a / 64) % 128);
  endfunction
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic send_pkt(bit wnr, logic [7:0] m, logic [aw-1:0] a);
    int n = 0;
    pkt = {wnr, m, a};
    pkt_v = 1;
    while (!pkt_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("pkt_accept", pkt_ready, 1'b1);
    @(negedge clk);
    pkt_v = 0;
  endtask
  task automatic write_block(logic [aw-1:0] a, logic [7:0] m, bit gaps);
    int b = blk_of(a);
    for (int i = 0; i < 8; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        d_v_i = 0;
        chk("wr_gap_rdy", d_rdy_o, 1'b1);
        @(negedge clk);
      end
      d_i = wbuf[i];
      d_v_i = 1;
      chk("wr_rdy", d_rdy_o, 1'b1);
      chk("wr_busy", pkt_ready, 1'b0);
      chk("wr_no_v", d_v_o, 1'b0);
      @(negedge clk);
      if (m[i]) mdl[b*8+i] = wbuf[i];
    end
    d_v_i = 0;
    chk("wr_done_pkt_rdy", pkt_ready, 1'b1);
    chk("wr_done_drdy", d_rdy_o, 1'b0);
  endtask
  task automatic read_block(logic [aw-1:0] a, int nb, int stall_beat, int stall_len, bit rnd);
    int b = blk_of(a);
    int s;
    d_v_i = 1;
    d_i = {$urandom, $urandom};
    chk("rd_latency", d_v_o, 1'b1);
    for (int i = 0; i < nb; i++) begin
      s = (i == stall_beat) ? stall_len : (rnd && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      d_rdy_i = 0;
      for (int k = 0; k < s; k++) begin
        chk("rd_hold_v", d_v_o, 1'b1);
        chk("rd_hold_data", d_o, mdl[b*8+i]);
        @(negedge clk);
      end
      d_rdy_i = 1;
      chk("rd_v", d_v_o, 1'b1);
      chk("rd_data", d_o, mdl[b*8+i]);
      chk("rd_no_wr_rdy", d_rdy_o, 1'b0);
      chk("rd_busy", pkt_ready, 1'b0);
      @(negedge clk);
    end
    d_rdy_i = 0;
    d_v_i = 0;
    if (nb == 8) begin
      chk("rd_done_pkt_rdy", pkt_ready, 1'b1);
      chk("rd_done_v", d_v_o, 1'b0);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [aw-1:0] a;
    logic [7:0] m;
    bit wnr;
    #1 reset_n = 0;
    #20;
    chk("rst_pkt_rdy", pkt_ready, 1'b0);
    chk("rst_v", d_v_o, 1'b0);
    chk("rst_drdy", d_rdy_o, 1'b0);
    chk("rst_data", d_o, 64'h0);
    @(negedge clk);
    reset_n = 1;
    #1 chk("rel_pkt_rdy", pkt_ready, 1'b1);
    @(negedge clk);
    for (int b = 0; b < 128; b++) begin
      for (int i = 0; i < 8; i++) wbuf[i] = {$urandom, $urandom};
      send_pkt(1, 8'hFF, aw'(b * 64));
      write_block(aw'(b * 64), 8'hFF, 0);
    end
    for (int i = 0; i < 8; i++) wbuf[i] = 64'h1000 + 64'(i);
    send_pkt(1, 8'hFF, 28'h40);
    write_block(28'h40, 8'hFF, 0);
    send_pkt(0, 8'h00, 28'h40);
    read_block(28'h40, 8, -1, 0, 0);
    chk("wr_rd_beat7", mdl[15], 64'h1007);
    for (int i = 0; i < 8; i++) wbuf[i] = 64'hAAAA;
    send_pkt(1, 8'hFF, 28'h80);
    write_block(28'h80, 8'hFF, 0);
    for (int i = 0; i < 8; i++) wbuf[i] = 64'h5555;
    send_pkt(1, 8'h05, 28'h80);
    write_block(28'h80, 8'h05, 0);
    chk("mask_model_w1", mdl[17], 64'hAAAA);
    send_pkt(0, 8'hFF, 28'h80);
    read_block(28'h80, 8, -1, 0, 0);
    send_pkt(0, 8'h00, 28'h40);
    read_block(28'h40, 8, 2, 3, 0);
    for (int i = 0; i < 8; i++) wbuf[i] = {$urandom, $urandom};
    send_pkt(1, 8'hFF, 28'h100);
    pkt = {1'b0, 8'hFF, 28'h100};
    pkt_v = 1;
    write_block(28'h100, 8'hFF, 1);
    @(negedge clk);
    pkt_v = 0;
    read_block(28'h100, 8, -1, 0, 0);
    for (int i = 0; i < 8; i++) wbuf[i] = {$urandom, $urandom};
    send_pkt(1, 8'hFF, 28'h0);
    write_block(28'h0, 8'hFF, 0);
    send_pkt(0, 8'hFF, 28'h2000);
    read_block(28'h2000, 8, -1, 0, 0);
    send_pkt(0, 8'h00, 28'h40);
    read_block(28'h40, 4, -1, 0, 0);
    #2 reset_n = 0;
    #1;
    chk("mid_rst_v", d_v_o, 1'b0);
    chk("mid_rst_pkt_rdy", pkt_ready, 1'b0);
    chk("mid_rst_data", d_o, 64'h0);
    @(negedge clk);
    reset_n = 1;
    #1;
    chk("mid_rel_pkt_rdy", pkt_ready, 1'b1);
    chk("mid_rel_v", d_v_o, 1'b0);
    @(negedge clk);
    send_pkt(0, 8'h00, 28'h40);
    read_block(28'h40, 8, -1, 0, 0);
    for (int t = 0; t < 150; t++) begin
      wnr = 1'($urandom_range(0, 1));
      a = aw'($urandom);
      m = $urandom_range(0, 3) == 0 ? 8'hFF : $urandom_range(0, 7) == 0 ? 8'h00 : 8'($urandom);
      if (wnr) begin
        for (int i = 0; i < 8; i++) wbuf[i] = {$urandom, $urandom};
        send_pkt(1, m, a);
        write_block(a, m, 1);
      end else begin
        send_pkt(0, m, a);
        read_block(a, 8, -1, 0, 1);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
